// File: rtl/key_word_collector_pkg.sv
// key_pkg: shared definitions for the locking-key word collector.
//   st_e            - collector FSM state encoding
//   KEY_WORD_W      - width of one readout word
//   KEY_NUM_WORDS   - words per collection run
//   KEY_ADDR_W      - readout address width
//   KEY_RD_LATENCY  - cycles from address driven to matching rd_data
package key_pkg;

    localparam int KEY_WORD_W     = 16;
    localparam int KEY_NUM_WORDS  = 4;
    localparam int KEY_ADDR_W     = 2;
    localparam int KEY_RD_LATENCY = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } st_e;

endpackage

// File: rtl/key_word_collector_if.sv
// key_word_collector_if: handshake and readout bus of the key word collector.
//   start     - request a collection run (driver -> collector)
//   busy      - run in progress
//   done      - one-cycle pulse, key_out updated
//   rd_addr   - address to the readout pipeline
//   rd_data   - word returned by the readout pipeline
//   key_out   - assembled key, word i at [i*WORD_W +: WORD_W]
//   key_valid - key_out holds a complete run
// With KEY_WORD_COLLECTOR_CMP_EN defined, also carries golden_key (in) and
// key_match (out).
// Modports: master = requester/readout side, slave = collector.
interface key_word_collector_if
    import key_pkg::*;
#(
    parameter int WORD_W    = KEY_WORD_W,
    parameter int NUM_WORDS = KEY_NUM_WORDS,
    parameter int ADDR_W    = KEY_ADDR_W
) ();

    logic                        start;
    logic                        busy;
    logic                        done;
    logic [ADDR_W-1:0]           rd_addr;
    logic [WORD_W-1:0]           rd_data;
    logic [WORD_W*NUM_WORDS-1:0] key_out;
    logic                        key_valid;
`ifdef KEY_WORD_COLLECTOR_CMP_EN
    logic [WORD_W*NUM_WORDS-1:0] golden_key;
    logic                        key_match;
`endif

    modport master (
        output start,
        output rd_data,
`ifdef KEY_WORD_COLLECTOR_CMP_EN
        output golden_key,
        input  key_match,
`endif
        input  busy,
        input  done,
        input  rd_addr,
        input  key_out,
        input  key_valid
    );

    modport slave (
        input  start,
        input  rd_data,
`ifdef KEY_WORD_COLLECTOR_CMP_EN
        input  golden_key,
        output key_match,
`endif
        output busy,
        output done,
        output rd_addr,
        output key_out,
        output key_valid
    );

endinterface

// File: rtl/key_word_collector_rd_tag_pipe.sv
// key_rd_tag_pipe: DEPTH-deep valid+index shift register that follows each
// issued read address through the readout latency. out_vld high in a cycle
// means rd_data in that cycle belongs to word out_idx.
//   clk, rst_n - clock, async active-low reset (clears all tags)
//   in_vld     - an address is being issued this cycle
//   in_idx     - word index of the issued address
//   out_vld    - tag emerging this cycle
//   out_idx    - word index of the emerging tag
module key_rd_tag_pipe #(
    parameter int DEPTH = 3,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx
);

    logic [DEPTH-1:0] vld_q;
    logic [IDX_W-1:0] idx_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            idx_q[0] <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_idx = idx_q[DEPTH-1];

endmodule

// File: rtl/key_word_collector.sv
// key_word_collector: on start, reads words 0..NUM_WORDS-1 from the locking-key
// readout pipeline back-to-back, captures each word when its tag emerges after
// RD_LATENCY cycles, and presents the assembled key with key_valid and a
// one-cycle done pulse.
//   clk   - clock, all state on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - key_word_collector_if.slave (start/busy/done, rd_addr/rd_data,
//           key_out/key_valid)
// Optional feature macro KEY_WORD_COLLECTOR_CMP_EN: adds golden_key input and
// a registered key_match output evaluated in DONE.
//
// state | meaning
// IDLE  | waiting for start; key_out/key_valid hold the last run
// ISSUE | driving rd_addr 0..NUM_WORDS-1, one per cycle
// DRAIN | rd_addr back at 0, waiting for the last tag to emerge
// DONE  | one cycle: done=1, key_valid=1
module key_word_collector
    import key_pkg::*;
#(
    parameter int WORD_W     = KEY_WORD_W,
    parameter int NUM_WORDS  = KEY_NUM_WORDS,
    parameter int ADDR_W     = KEY_ADDR_W,
    parameter int RD_LATENCY = KEY_RD_LATENCY
) (
    input  logic                clk,
    input  logic                rst_n,
    key_word_collector_if.slave bus
);

    localparam int                KEY_W     = WORD_W * NUM_WORDS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    st_e               state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] issue_cnt_q;
    logic [ADDR_W-1:0] capture_cnt_q;
    logic [KEY_W-1:0]  key_q;
    logic              key_valid_q;

    logic              start_acc;
    logic              last_issue;
    logic              last_capture;
    logic              tag_in_vld;
    logic              tag_out_vld;
    logic [ADDR_W-1:0] tag_out_idx;

    assign start_acc    = (state_q == IDLE) && bus.start;
    assign tag_in_vld   = (state_q == ISSUE);
    assign last_issue   = (state_q == ISSUE) && (issue_cnt_q == LAST_ADDR);
    // Tags emerge in issue order, so the NUM_WORDS-th capture is the last one.
    assign last_capture = tag_out_vld && (capture_cnt_q == LAST_ADDR);

    key_rd_tag_pipe #(
        .DEPTH (RD_LATENCY),
        .IDX_W (ADDR_W)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (tag_in_vld),
        .in_idx  (issue_cnt_q),
        .out_vld (tag_out_vld),
        .out_idx (tag_out_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)    state_d = ISSUE;
            ISSUE:   if (last_issue)   state_d = DRAIN;
            DRAIN:   if (last_capture) state_d = DONE;
            DONE:                      state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // rd_addr is the registered copy of the next issue index so that address
    // k is on the bus during the k-th ISSUE cycle; it parks at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q   <= '0;
            issue_cnt_q <= '0;
        end else if (start_acc) begin
            rd_addr_q   <= '0;
            issue_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            if (last_issue) begin
                rd_addr_q   <= '0;
                issue_cnt_q <= '0;
            end else begin
                rd_addr_q   <= issue_cnt_q + 1'b1;
                issue_cnt_q <= issue_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capture_cnt_q <= '0;
            key_q         <= '0;
        end else begin
            if (start_acc || last_capture) begin
                capture_cnt_q <= '0;
            end else if (tag_out_vld) begin
                capture_cnt_q <= capture_cnt_q + 1'b1;
            end
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (tag_out_vld && (tag_out_idx == ADDR_W'(i))) begin
                    key_q[i*WORD_W +: WORD_W] <= bus.rd_data;
                end
            end
        end
    end

    // key_valid rises together with the DONE cycle and holds until the next
    // accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_q <= 1'b0;
        end else if (start_acc) begin
            key_valid_q <= 1'b0;
        end else if ((state_q == DRAIN) && last_capture) begin
            key_valid_q <= 1'b1;
        end
    end

`ifdef KEY_WORD_COLLECTOR_CMP_EN
    logic key_match_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_match_q <= 1'b0;
        end else if (start_acc) begin
            key_match_q <= 1'b0;
        end else if (state_q == DONE) begin
            key_match_q <= (key_q == bus.golden_key);
        end
    end

    assign bus.key_match = key_match_q;
`endif

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.rd_addr   = rd_addr_q;
    assign bus.key_out   = key_q;
    assign bus.key_valid = key_valid_q;

endmodule

// File: tb/tb_key_word_collector.sv
// Self-checking bench for key_word_collector: a 3-stage readout source model,
// a per-cycle reference model of run timing and key contents, a vector table
// for the basic run, hand sequences for corner cases, and a random phase.
module tb_key_word_collector;

    localparam logic [63:0] KEY_BASIC = 64'h4444_3333_2222_1111;
    localparam logic [63:0] KEY_BEEF  = 64'h4444_BEEF_2222_1111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_word_collector_if bus ();

    key_word_collector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          acc_c    = -1;
    bit          exp_issue = 1'b0;
    logic [15:0] mem [4];
    logic [15:0] p1 = '0, p2 = '0, p3 = '0;
    logic [63:0] run_key  = '0;
    logic [63:0] run_gold = '0;
    logic [63:0] golden   = KEY_BASIC;

    // Readout source: data for an address appears three cycles later. Cycles
    // in which no address should be issued return noise that must be ignored.
    always @(posedge clk) begin
        p1 <= exp_issue ? mem[bus.rd_addr] : 16'($urandom);
        p2 <= p1;
        p3 <= p2;
    end
    assign bus.rd_data = p3;
`ifdef KEY_WORD_COLLECTOR_CMP_EN
    assign bus.golden_key = golden;
`endif

    typedef struct {
        bit         start;
        logic [1:0] addr;
        bit         busy;
        bit         done;
        bit         kv;
    } vec_t;
    vec_t vecs [11];

    function automatic logic [63:0] mem_key();
        return {mem[3], mem[2], mem[1], mem[0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    // One cycle: at mid-cycle compare outputs with the model, optionally change
    // source contents while idle, drive start, advance the model.
    task automatic step(input bit st, input bit chg);
        int k;
        bit active;
        @(negedge clk);
        k      = (acc_c < 0) ? -1 : cyc - acc_c;
        active = (acc_c >= 0) && (k >= 1) && (k <= 8);
        chk("busy", 64'(bus.busy), 64'(active));
        chk("done", 64'(bus.done), 64'(active && k == 8));
        chk("rd_addr", 64'(bus.rd_addr), (active && k <= 4) ? 64'(k - 1) : 64'd0);
        chk("key_valid", 64'(bus.key_valid), 64'(acc_c >= 0 && k >= 8));
        if (acc_c >= 0 && k >= 8) chk("key_out", bus.key_out, run_key);
`ifdef KEY_WORD_COLLECTOR_CMP_EN
        chk("key_match", 64'(bus.key_match), 64'(acc_c >= 0 && k >= 9 && run_key == run_gold));
`endif
        if (!active && chg) begin
            for (int i = 0; i < 4; i++) mem[i] = 16'($urandom);
            if ($urandom_range(0, 1) == 1) golden = mem_key();
            else golden = mem_key() ^ (64'h1 << $urandom_range(0, 63));
        end
        bus.start = st;
        if (!active && st && rst_n) begin
            acc_c    = cyc;
            run_key  = mem_key();
            run_gold = golden;
        end
        exp_issue = (acc_c >= 0) && (cyc - acc_c >= 1) && (cyc - acc_c <= 4);
        cyc++;
    endtask

    task automatic do_run();
        step(1'b1, 1'b0);
        repeat (9) step(1'b0, 1'b0);
    endtask

    initial begin
        int dn;
        int dc [$];

        bus.start = 1'b0;
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        for (int i = 0; i < 11; i++) vecs[i] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 2'd2, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 2'd3, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step(1'b0, 1'b0);
        chk("rst_key_out", bus.key_out, 64'd0);
`ifdef KEY_WORD_COLLECTOR_CMP_EN
        chk("rst_key_match", 64'(bus.key_match), 64'd0);
`endif

        // Basic run from the vector table.
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].start, 1'b0);
            chk("tbl_rd_addr", 64'(bus.rd_addr), 64'(vecs[i].addr));
            chk("tbl_busy", 64'(bus.busy), 64'(vecs[i].busy));
            chk("tbl_done", 64'(bus.done), 64'(vecs[i].done));
            chk("tbl_key_valid", 64'(bus.key_valid), 64'(vecs[i].kv));
            if (i == 9) begin
                chk("basic_key", bus.key_out, KEY_BASIC);
`ifdef KEY_WORD_COLLECTOR_CMP_EN
                chk("basic_match", 64'(bus.key_match), 64'd1);
`endif
            end
        end

        // Same key, golden off by one bit; match clears on start.
        golden = KEY_BASIC ^ (64'h1 << 37);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
`ifdef KEY_WORD_COLLECTOR_CMP_EN
        chk("match_clear", 64'(bus.key_match), 64'd0);
`endif
        repeat (8) step(1'b0, 1'b0);
        chk("miss_key", bus.key_out, KEY_BASIC);
`ifdef KEY_WORD_COLLECTOR_CMP_EN
        chk("miss_match", 64'(bus.key_match), 64'd0);
`endif

        // Word 2 changed between runs.
        mem[2] = 16'hBEEF;
        golden = KEY_BEEF;
        do_run();
        chk("beef_key", bus.key_out, KEY_BEEF);

        // start re-asserted while busy.
        dn = 0;
        step(1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step(k >= 2 && k <= 7, 1'b0);
            if (bus.done) dn++;
            if (k <= 4) chk("reasrt_addr", 64'(bus.rd_addr), 64'(k - 1));
        end
        chk("reasrt_done_cnt", 64'(dn), 64'd1);

        // start held high for 20 cycles.
        for (int j = 0; j < 35; j++) begin
            step(j < 20, 1'b0);
            if (bus.done) dc.push_back(j);
            if (j == 12) chk("held_kv_low", 64'(bus.key_valid), 64'd0);
        end
        chk("held_done_cnt", 64'(dc.size()), 64'd3);
        if (dc.size() == 3) begin
            chk("held_done0", 64'(dc[0]), 64'd8);
            chk("held_done1", 64'(dc[1]), 64'd17);
            chk("held_done2", 64'(dc[2]), 64'd26);
        end

        // Reset in cycle 5 of a run, released two cycles later.
        step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        rst_n     = 1'b0;
        acc_c     = -1;
        exp_issue = 1'b0;
        #1;
        chk("mrst_busy", 64'(bus.busy), 64'd0);
        chk("mrst_done", 64'(bus.done), 64'd0);
        chk("mrst_rd_addr", 64'(bus.rd_addr), 64'd0);
        chk("mrst_key_out", bus.key_out, 64'd0);
        chk("mrst_key_valid", 64'(bus.key_valid), 64'd0);
`ifdef KEY_WORD_COLLECTOR_CMP_EN
        chk("mrst_key_match", 64'(bus.key_match), 64'd0);
`endif
        repeat (2) step(1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (8) begin
            step(1'b0, 1'b0);
            chk("no_stale_cap", bus.key_out, 64'd0);
        end
        do_run();
        chk("post_rst_key", bus.key_out, KEY_BEEF);

        // Random starts and source contents against the model.
        repeat (400) step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        repeat (12) step(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
